// File: rtl/ooo_pkg.sv
// Shared decode constants, FSM state and register-index types
// for the in-order issue controller.
package ooo_pkg;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_IMM   = 2'b01;
    localparam logic [1:0] OP_JMP   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [1:0] SUB_ADDI = 2'b00;
    localparam logic [1:0] SUB_LD   = 2'b01;
    localparam logic [1:0] SUB_ST   = 2'b10;
    localparam logic [1:0] SUB_NONE = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [1:0] reg_idx_t;

    function automatic logic [3:0] onehot(input reg_idx_t idx);
        return 4'b0001 << idx;
    endfunction

    // Every register the instruction reads or writes.
    function automatic logic [3:0] reg_mask(input logic [7:0] instr);
        logic [3:0] m;
        m = '0;
        unique case (instr[7:6])
            OP_RTYPE: m = onehot(instr[5:4]) | onehot(instr[3:2]);
            OP_IMM:   m = (instr[5:4] != SUB_NONE) ? onehot(instr[3:2]) : '0;
            default:  m = '0;
        endcase
        return m;
    endfunction

    function automatic logic writes_rt(input logic [7:0] instr);
        return (instr[7:6] == OP_RTYPE) ||
               ((instr[7:6] == OP_IMM) &&
                ((instr[5:4] == SUB_ADDI) || (instr[5:4] == SUB_LD)));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Four busy bits with writeback bypass on the lookup path;
// a same-cycle set of the cleared register keeps it busy.
module reg_scoreboard
    import ooo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  reg_idx_t   set_reg,
    input  logic       clr_en,
    input  reg_idx_t   clr_reg,
    input  logic [3:0] chk_mask,
    output logic       hit
);

    logic [3:0] busy;
    logic [3:0] busy_byp;
    logic [3:0] busy_nxt;

    always_comb begin
        busy_byp = busy;
        if (clr_en) busy_byp[clr_reg] = 1'b0;
        busy_nxt = busy_byp;
        if (set_en) busy_nxt[set_reg] = 1'b1;
    end

    assign hit = |(busy_byp & chk_mask);

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue controller with RAW/WAW stall and JMP flush.
// Stall-cycle counter is built only with ISSUE_CTRL_PERF_CNT_EN.
module issue_ctrl
    import ooo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_instr,
    output logic        in_ready,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [7:0]  issue_instr,
    input  logic        wb_valid,
    input  logic [1:0]  wb_reg,
    output logic        flush,
    output logic        stall,
    output logic [15:0] stall_cycles
);

    state_t     state;
    state_t     state_nxt;
    logic       hold_valid;
    logic [7:0] hold_instr;
    logic       hazard;
    logic       fire;
    logic       load;
    logic       is_jmp;

    assign is_jmp = hold_instr[7:6] == OP_JMP;

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire && writes_rt(hold_instr)),
        .set_reg  (hold_instr[3:2]),
        .clr_en   (wb_valid),
        .clr_reg  (wb_reg),
        .chk_mask (reg_mask(hold_instr)),
        .hit      (hazard)
    );

    assign issue_valid = !rst && hold_valid && !hazard && (state == RUN);
    assign fire        = issue_valid && issue_ready;
    // A departing JMP must not pull in the wrong-path successor.
    assign in_ready    = !rst && (state == RUN) &&
                         (!hold_valid || (fire && !is_jmp));
    assign load        = in_valid && in_ready;
    assign issue_instr = (!rst && hold_valid) ? hold_instr : '0;
    assign flush       = !rst && (state == FLUSH);
    assign stall       = !rst && (state == STALL);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_instr <= '0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_instr <= in_instr;
        end else if (fire) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (hold_valid && hazard)  state_nxt = STALL;
                else if (fire && is_jmp)   state_nxt = FLUSH;
            end
            STALL: if (!hazard) state_nxt = RUN;
            FLUSH: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

`ifdef ISSUE_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state == STALL) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_cycles = rst ? '0 : stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: scoreboard of issued
// instructions plus per-scenario control checks.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_instr = '0;
    logic        in_ready;
    logic        issue_valid;
    logic        issue_ready = 1'b1;
    logic [7:0]  issue_instr;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_reg = '0;
    logic        flush;
    logic        stall;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_instr  (issue_instr),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .flush        (flush),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got %h", issue_instr);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (issue_instr !== e) begin
                    errors++;
                    $display("FAIL issue_order got %h exp %h", issue_instr, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        issue_ready = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
        #1;
    endtask

    task automatic send(input logic [7:0] ins);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(ins);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr %h never accepted", ins);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, issue_valid, flush, stall} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000",
                     {in_ready, issue_valid, flush, stall});
        end
        checks++;
        if (issue_instr !== 8'h00 || stall_cycles !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h exp 00/0000",
                     issue_instr, stall_cycles);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_raw_stall();
        do_reset();
        send(8'h04);
        send(8'h14);
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL raw_hazard issue_valid got %b exp 0", issue_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (stall !== 1'b1 || issue_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall cyc %0d got s%b v%b r%b exp s1 v0 r0",
                         i, stall, issue_valid, in_ready);
            end
        end
        wb_valid = 1'b1;
        wb_reg = 2'd1;
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || issue_valid !== 1'b1 || issue_instr !== 8'h14) begin
            errors++;
            $display("FAIL raw_release got s%b v%b %h exp s0 v1 14",
                     stall, issue_valid, issue_instr);
        end
        tick();
    endtask

    task automatic test_jmp_flush();
        do_reset();
        send(8'h80);
        in_valid = 1'b1;
        in_instr = 8'hC4;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || in_ready !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL jmp_issue got v%b r%b f%b exp v1 r0 f0",
                     issue_valid, in_ready, flush);
        end
        tick();
        checks++;
        if (flush !== 1'b1 || in_ready !== 1'b0 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL jmp_flush got f%b r%b v%b exp f1 r0 v0",
                     flush, in_ready, issue_valid);
        end
        tick();
        checks++;
        if (flush !== 1'b0 || issue_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL jmp_after got f%b v%b r%b exp f0 v0 r1",
                     flush, issue_valid, in_ready);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        issue_ready = 1'b0;
        send(8'h20);
        in_valid = 1'b1;
        in_instr = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (issue_valid !== 1'b1 || issue_instr !== 8'h20 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got v%b %h r%b exp v1 20 r0",
                         i, issue_valid, issue_instr, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        issue_ready = 1'b1;
        tick();
        checks++;
        if (issue_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_drain got v%b r%b exp v0 r1", issue_valid, in_ready);
        end
    endtask

    task automatic test_wb_same_cycle();
        do_reset();
        send(8'h58);
        send(8'h08);
        wb_valid = 1'b1;
        wb_reg = 2'd2;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL wb_bypass got v%b s%b exp v1 s0", issue_valid, stall);
        end
        tick();
        wb_valid = 1'b0;
        send(8'h68);
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL set_wins issue_valid got %b exp 0", issue_valid);
        end
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_stall got %b exp 1", stall);
        end
        wb_valid = 1'b1;
        wb_reg = 2'd2;
        tick();
        wb_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] ld_ops [4] = '{8'h50, 8'h54, 8'h58, 8'h5C};
        logic [7:0] st_ops [4] = '{8'h60, 8'h64, 8'h68, 8'h6C};
        do_reset();
        foreach (ld_ops[i]) send(ld_ops[i]);
        send(8'h00);
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_stall got %b exp 1", stall);
        end
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || stall !== 1'b0 ||
            issue_valid !== 1'b0 || stall_cycles !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got r%b s%b v%b c%0d exp r1 s0 v0 c0",
                     in_ready, stall, issue_valid, stall_cycles);
        end
        issue_ready = 1'b0;
        foreach (st_ops[i]) begin
            send(st_ops[i]);
            checks++;
            if (issue_valid !== 1'b1) begin
                errors++;
                $display("FAIL mid_busy_clear r%0d issue_valid got %b exp 1",
                         i, issue_valid);
            end
            issue_ready = 1'b1;
            tick();
            issue_ready = 1'b0;
        end
        issue_ready = 1'b1;
    endtask

    task automatic test_stall_count();
        logic [15:0] exp_cnt;
`ifdef ISSUE_CTRL_PERF_CNT_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        do_reset();
        send(8'h5C);
        send(8'h6C);
        for (int i = 0; i < 10; i++) tick();
        wb_valid = 1'b1;
        wb_reg = 2'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL count_in_stall got %b exp 1", stall);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || stall_cycles !== exp_cnt) begin
            errors++;
            $display("FAIL stall_count got s%b %0d exp s0 %0d",
                     stall, stall_cycles, exp_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_jmp_flush();
        test_backpressure();
        test_wb_same_cycle();
        test_reset_mid();
        test_stall_count();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
